// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter: icache/dcache arbiter for a single-ported tagged memory bus
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = `XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2Imem_command,
  input  logic [XLEN-1:0] proc2Imem_addr,
  input  logic [1:0]      proc2Dmem_command,
  input  logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [63:0]     proc2Dmem_data,
  input  logic [3:0]      mem2ctrl_response,
  input  logic [63:0]     mem2ctrl_data,
  input  logic [3:0]      mem2ctrl_tag,
  output logic [1:0]      ctrl2mem_command,
  output logic [XLEN-1:0] ctrl2mem_addr,
  output logic [63:0]     ctrl2mem_data,
  output logic            d_request,
  output logic [3:0]      Imem2proc_response,
  output logic [3:0]      Dmem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      Imem2proc_tag,
  output logic [3:0]      Dmem2proc_tag,
  output logic [3:0]      outstanding_cnt,
  output logic            bus_idle
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic        i_req;
  logic        d_req;
  logic        force_i;
  logic        d_grant;
  logic        i_grant;
  logic        alloc;
  logic        ret_valid;
  logic [15:0] busy;
  logic [15:0] owner;
  logic [15:0] busy_next;
  logic [15:0] owner_next;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  logic [3:0]  cnt_next;

  assign i_req   = (proc2Imem_command == BUS_LOAD);
  assign d_req   = (proc2Dmem_command != BUS_NONE);
  assign force_i = i_req && (starve_cnt >= LIMIT);
  assign d_grant = d_req && !force_i;
  assign i_grant = !d_grant && i_req;

  always_comb begin
    ctrl2mem_command = BUS_NONE;
    ctrl2mem_addr    = '0;
    ctrl2mem_data    = '0;
    if (d_grant) begin
      ctrl2mem_command = proc2Dmem_command;
      ctrl2mem_addr    = proc2Dmem_addr;
      ctrl2mem_data    = proc2Dmem_data;
    end else if (i_grant) begin
      ctrl2mem_command = BUS_LOAD;
      ctrl2mem_addr    = proc2Imem_addr;
    end
  end

  assign d_request          = d_grant;
  assign Dmem2proc_response = d_grant ? mem2ctrl_response : 4'd0;
  assign Imem2proc_response = i_grant ? mem2ctrl_response : 4'd0;
  assign mem2proc_data      = mem2ctrl_data;

  // Only accepted loads own a tag; stores complete on acceptance.
  assign alloc = ((d_grant && (proc2Dmem_command == BUS_LOAD)) || i_grant)
                 && (mem2ctrl_response != 4'd0);

  // Bit 0 of busy is never set, so tag 0 can never look valid.
  assign ret_valid     = (mem2ctrl_tag != 4'd0) && busy[mem2ctrl_tag];
  assign Dmem2proc_tag = (ret_valid &&  owner[mem2ctrl_tag]) ? mem2ctrl_tag : 4'd0;
  assign Imem2proc_tag = (ret_valid && !owner[mem2ctrl_tag]) ? mem2ctrl_tag : 4'd0;

  assign bus_idle = (outstanding_cnt == 4'd0) && (ctrl2mem_command == BUS_NONE);

  // Return is applied before allocate so a same-tag reuse keeps busy set.
  always_comb begin
    busy_next  = busy;
    owner_next = owner;
    if (ret_valid) begin
      busy_next[mem2ctrl_tag] = 1'b0;
    end
    if (alloc) begin
      busy_next[mem2ctrl_response]  = 1'b1;
      owner_next[mem2ctrl_response] = d_grant;
    end
  end

  always_comb begin
    cnt_next = outstanding_cnt;
    case ({alloc, ret_valid})
      2'b10:   cnt_next = outstanding_cnt + 4'd1;
      2'b01:   cnt_next = outstanding_cnt - 4'd1;
      default: cnt_next = outstanding_cnt;
    endcase
  end

  always_comb begin
    starve_next = starve_cnt;
    if (i_req && d_grant) begin
      starve_next = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
    end else if (i_grant) begin
      starve_next = 4'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy            <= '0;
      owner           <= '0;
      starve_cnt      <= 4'd0;
      outstanding_cnt <= 4'd0;
    end else begin
      busy            <= busy_next;
      owner           <= owner_next;
      starve_cnt      <= starve_next;
      outstanding_cnt <= cnt_next;
    end
  end

endmodule

`default_nettype wire
